crc_rx_checker: RTL and testbench

CRC_RX_CHECKER -- requirements
Module: crc_rx_checker

---
 rtl/crc_pkg.sv | 19 +
 rtl/crc_lfsr_step.sv | 21 ++
 rtl/crc_rx_checker.sv | 92 +++++++++
 tb/tb_crc_rx_checker.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/crc_pkg.sv
// Shared CRC defaults and receive FSM encoding.
// Used by the serial checker and the controller's CRC generator.
package crc_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int CRC_W_DEF  = 4;
   localparam logic [3:0] POLY_DEF = 4'b0011;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } crc_state_e;

   function automatic logic [3:0] frame_len(input int dw, input int cw);
      return 4'(dw + cw);
   endfunction

endpackage

// File: rtl/crc_lfsr_step.sv
// One serial step of an MSB-first CRC register.
// Pure combinational so the generator can reuse it.
module crc_lfsr_step
   import crc_pkg::*;
#(
   parameter int W = CRC_W_DEF,
   parameter logic [W-1:0] POLY = POLY_DEF
) (
   input  logic [W-1:0] r,
   input  logic         bit_in,
   output logic [W-1:0] r_next
);

   logic fb;

   always_comb begin
      fb     = r[W-1] ^ bit_in;
      r_next = {r[W-2:0], 1'b0} ^ (fb ? POLY : '0);
   end

endmodule

// File: rtl/crc_rx_checker.sv
// Serial codeword receiver: collects the payload and checks
// the trailing CRC bits against a running remainder.
module crc_rx_checker
   import crc_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int CRC_W  = CRC_W_DEF,
   parameter logic [CRC_W-1:0] POLY = POLY_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              bit_valid,
   input  logic              bit_in,
   output logic              busy,
   output logic              frame_done,
   output logic [DATA_W-1:0] data_out,
   output logic              crc_err,
   output logic [3:0]        bit_cnt
);

   localparam logic [3:0] TOTAL = frame_len(DATA_W, CRC_W);
   localparam logic [3:0] DW4   = 4'(DATA_W);

   crc_state_e        state;
   logic [CRC_W-1:0]  lfsr;
   logic [CRC_W-1:0]  lfsr_nx;
   logic [DATA_W-1:0] payload;

   crc_lfsr_step #(
      .W    (CRC_W),
      .POLY (POLY)
   ) u_step (
      .r      (lfsr),
      .bit_in (bit_in),
      .r_next (lfsr_nx)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         data_out   <= '0;
         crc_err    <= 1'b0;
         bit_cnt    <= '0;
         lfsr       <= '0;
         payload    <= '0;
      end else begin
         frame_done <= 1'b0;
         // start restarts from any state; DONE outputs were
         // already latched on the edge that entered DONE
         if (start) begin
            state   <= SHIFT;
            busy    <= 1'b1;
            bit_cnt <= '0;
            lfsr    <= '0;
            payload <= '0;
         end else begin
            unique case (state)
               IDLE: begin
                  state <= IDLE;
               end
               SHIFT: begin
                  if (bit_valid) begin
                     lfsr <= lfsr_nx;
                     if (bit_cnt < TOTAL)
                        bit_cnt <= bit_cnt + 4'd1;
                     if (bit_cnt < DW4)
                        payload <= {payload[DATA_W-2:0], bit_in};
                     if (bit_cnt == TOTAL - 4'd1) begin
                        state      <= DONE;
                        frame_done <= 1'b1;
                        data_out   <= payload;
                        crc_err    <= |lfsr_nx;
                     end
                  end
               end
               DONE: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_crc_rx_checker.sv
// Directed bench for crc_rx_checker: table of frames plus
// hand-written abort, reset and restart sequences.
module tb_crc_rx_checker;

   logic       clk;
   logic       reset;
   logic       start;
   logic       bit_valid;
   logic       bit_in;
   logic       busy;
   logic       frame_done;
   logic [7:0] data_out;
   logic       crc_err;
   logic [3:0] bit_cnt;

   int n_vec;
   int n_err;
   int done_cnt;

   crc_rx_checker dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .bit_valid  (bit_valid),
      .bit_in     (bit_in),
      .busy       (busy),
      .frame_done (frame_done),
      .data_out   (data_out),
      .crc_err    (crc_err),
      .bit_cnt    (bit_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [11:0] word;
      int          gap;
      logic [7:0]  exp_data;
      logic        exp_err;
      string       name;
   } vec_t;

   vec_t tbl[5];

   task automatic step();
      @(posedge clk);
      #1;
      if (frame_done) done_cnt++;
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic send_frame(input logic [11:0] w, input int gap,
                             input bit do_start, input bit do_idle,
                             input logic [7:0] ed, input logic ee,
                             input string nm);
      int d0;
      bit bok;
      bit early;
      if (do_start) begin
         start = 1'b1;
         bit_valid = 1'b0;
         step();
         start = 1'b0;
         chk({nm, ":cnt0"}, 32'(bit_cnt), 0);
      end
      d0 = done_cnt;
      bok = 1'b1;
      early = 1'b0;
      for (int i = 11; i >= 0; i--) begin
         bit_valid = 1'b1;
         bit_in = w[i];
         step();
         bit_valid = 1'b0;
         if (i > 0) begin
            if (!busy || frame_done) bok = 1'b0;
            if (frame_done) early = 1'b1;
            for (int g = 0; g < gap; g++) begin
               step();
               if (!busy || frame_done) bok = 1'b0;
            end
         end
      end
      chk({nm, ":busy_mid"}, 32'(bok), 1);
      chk({nm, ":no_early"}, 32'(early), 0);
      chk({nm, ":done"}, 32'(frame_done), 1);
      chk({nm, ":ndone"}, 32'(done_cnt - d0), 1);
      chk({nm, ":data"}, 32'(data_out), 32'(ed));
      chk({nm, ":err"}, 32'(crc_err), 32'(ee));
      chk({nm, ":busy_done"}, 32'(busy), 1);
      chk({nm, ":cnt"}, 32'(bit_cnt), 12);
      if (do_idle) begin
         step();
         chk({nm, ":done_low"}, 32'(frame_done), 0);
         chk({nm, ":idle"}, 32'(busy), 0);
         chk({nm, ":hold"}, 32'({crc_err, data_out}), 32'({ee, ed}));
      end
   endtask

   initial begin
      int d0;
      n_vec = 0;
      n_err = 0;
      done_cnt = 0;
      reset = 1'b1;
      start = 1'b0;
      bit_valid = 1'b0;
      bit_in = 1'b0;

      tbl[0] = '{12'hA5B, 0, 8'hA5, 1'b0, "a5b"};
      tbl[1] = '{12'hADB, 0, 8'hAD, 1'b1, "adb_flip"};
      tbl[2] = '{12'h000, 1, 8'h00, 1'b0, "zero_toggle"};
      tbl[3] = '{12'hA5A, 0, 8'hA5, 1'b1, "a5a_badcrc"};
      tbl[4] = '{12'hA5B, 3, 8'hA5, 1'b0, "a5b_gap3"};

      step();
      step();
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(frame_done), 0);
      chk("rst_data", 32'(data_out), 0);
      chk("rst_err", 32'(crc_err), 0);
      chk("rst_cnt", 32'(bit_cnt), 0);
      reset = 1'b0;

      bit_valid = 1'b1;
      bit_in = 1'b1;
      step();
      step();
      bit_valid = 1'b0;
      chk("idle_ignore", 32'({busy, bit_cnt}), 0);

      foreach (tbl[k])
         send_frame(tbl[k].word, tbl[k].gap, 1'b1, 1'b1,
                    tbl[k].exp_data, tbl[k].exp_err, tbl[k].name);

      // abort after 6 bits, then a full frame
      d0 = done_cnt;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         bit_valid = 1'b1;
         bit_in = i[0];
         step();
      end
      bit_valid = 1'b0;
      chk("abort_cnt6", 32'(bit_cnt), 6);
      send_frame(12'hA5B, 0, 1'b1, 1'b1, 8'hA5, 1'b0, "abort");
      chk("abort_one_done", 32'(done_cnt - d0), 1);

      // reset mid-frame after 7 bits
      d0 = done_cnt;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 7; i++) begin
         bit_valid = 1'b1;
         bit_in = 1'b1;
         step();
      end
      bit_valid = 1'b0;
      reset = 1'b1;
      step();
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_cnt", 32'(bit_cnt), 0);
      chk("mid_rst_data", 32'(data_out), 0);
      chk("mid_rst_nodone", 32'(done_cnt - d0), 0);
      reset = 1'b0;
      step();

      // start together with a valid bit: the bit is dropped
      start = 1'b1;
      bit_valid = 1'b1;
      bit_in = 1'b1;
      step();
      start = 1'b0;
      bit_valid = 1'b0;
      chk("start_wins_cnt", 32'(bit_cnt), 0);
      send_frame(12'hA5B, 0, 1'b0, 1'b0, 8'hA5, 1'b0, "start_wins");

      // start during DONE: restart straight into SHIFT
      start = 1'b1;
      step();
      start = 1'b0;
      chk("done_start_busy", 32'(busy), 1);
      chk("done_start_cnt", 32'(bit_cnt), 0);
      chk("done_start_pulse", 32'(frame_done), 0);
      chk("done_start_held", 32'(data_out), 32'h A5);
      send_frame(12'hADB, 0, 1'b0, 1'b1, 8'hAD, 1'b1, "after_done");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
